// File: rtl/easy6502_io_map.sv
// easy6502-style memory-mapped I/O in front of the CPU data input:
// $FD frame counter, $FE pseudo-random byte, $FF last key byte, else RAM data.
module easy6502_io_map #(
  parameter logic [15:0] SEED             = 16'hACE1,
  parameter bit          VSYNC_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_address,
  input  logic        cpu_write_en,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_ready,
  input  logic [7:0]  ram_rdata,
  input  logic        key_valid,
  input  logic [7:0]  key_data,
  input  logic        vsync,
  output logic [7:0]  cpu_rdata
);

  // A zero seed would lock the LFSR at zero forever.
  localparam logic [15:0] LFSR_INIT  = (SEED == 16'h0000) ? 16'hACE1 : SEED;
  localparam logic [15:0] LFSR_TAPS  = 16'hB400;
  localparam logic        VSYNC_IDLE = VSYNC_ACTIVE_LOW;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_FD   = 2'd1,
    SEL_FE   = 2'd2,
    SEL_FF   = 2'd3
  } sel_t;

  sel_t        sel_q;
  sel_t        sel_d;
  logic [7:0]  io_q;
  logic [7:0]  io_d;
  logic [15:0] lfsr;
  logic [15:0] lfsr_next;
  logic [7:0]  key_q;
  logic [7:0]  frame_q;
  logic        vsync_d;
  logic        vsync_now_active;
  logic        vsync_was_active;
  logic        tick;
  logic        cpu_wr;
  logic        wr_fd;
  logic        wr_ff;

  always_comb begin
    sel_d = SEL_NONE;
    case (cpu_address)
      16'h00FD: sel_d = SEL_FD;
      16'h00FE: sel_d = SEL_FE;
      16'h00FF: sel_d = SEL_FF;
      default:  sel_d = SEL_NONE;
    endcase
  end

  always_comb begin
    io_d = 8'h00;
    case (sel_d)
      SEL_FD:  io_d = frame_q;
      SEL_FE:  io_d = lfsr[7:0];
      SEL_FF:  io_d = key_q;
      default: io_d = 8'h00;
    endcase
  end

  assign lfsr_next        = (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
  assign vsync_now_active = (vsync != VSYNC_IDLE);
  assign vsync_was_active = (vsync_d != VSYNC_IDLE);
  assign tick             = vsync_now_active && !vsync_was_active;
  assign cpu_wr           = cpu_write_en && cpu_ready;
  assign wr_fd            = cpu_wr && (cpu_address == 16'h00FD);
  assign wr_ff            = cpu_wr && (cpu_address == 16'h00FF);

  // cpu_ready acts as a capture enable: while it is low sel_q/io_q hold so
  // DI stays stable through a stall; the LFSR, key and frame logic keep running.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel_q   <= SEL_NONE;
      io_q    <= 8'h00;
      lfsr    <= LFSR_INIT;
      key_q   <= 8'h00;
      frame_q <= 8'h00;
      vsync_d <= VSYNC_IDLE;
    end else begin
      if (cpu_ready) begin
        sel_q <= sel_d;
        io_q  <= io_d;
      end
      lfsr    <= lfsr_next;
      vsync_d <= vsync;
      if (key_valid) begin
        key_q <= key_data;
      end else if (wr_ff) begin
        key_q <= cpu_wdata;
      end
      if (wr_fd) begin
        frame_q <= 8'h00;
      end else if (tick) begin
        frame_q <= frame_q + 8'd1;
      end
    end
  end

  assign cpu_rdata = (sel_q == SEL_NONE) ? ram_rdata : io_q;

endmodule
